// File: rtl/data_mem_if.sv
// Pipeline memory-initiator bus plus host byte-write port and status lines.
// No latency of its own; pure signal bundle.
// Host backpressure is carried by host_ready_o; the pipeline port never stalls.
interface data_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [3:0]        mem_width_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [7:0]        host_data_i;
    logic              host_ready_o;
    logic              init_done_o;
    logic              err_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        output host_we_i, host_addr_i, host_data_i,
        input  mem_data_o, host_ready_o, init_done_o, err_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        input  host_we_i, host_addr_i, host_data_i,
        output mem_data_o, host_ready_o, init_done_o, err_o
    );
endinterface

// File: rtl/data_mem.sv
// Byte-addressed big-endian data memory, 1-4 byte accesses at any alignment, zero-filled after reset.
// Reads: 1 cycle registered latency; writes commit at the sampling edge.
// Pipeline never stalls; host writes are refused while clearing or when the pipeline writes.
module data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    data_mem_if.slave    bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int ROWS = DEPTH / 4;
    localparam int RW   = AW - 2;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RW-1:0]     clr_row;

    logic [7:0]        mem [4][ROWS];

    logic              legal;
    logic              acc_wr;
    logic              acc_rd;
    logic              host_rdy;
    logic              host_acc;
    logic [AW-1:0]     host_byte;
    logic [AW-1:0]     byte_addr [4];
    logic [DATA_W-1:0] wr_aligned;
    logic [DATA_W-1:0] rd_word;

    logic [3:0]        bank_we;
    logic [RW-1:0]     bank_row  [4];
    logic [7:0]        bank_wdat [4];

    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // State register and clear-sweep row counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_row <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_row <= clr_row + 1'b1;
            end
        end
    end

    // Leave CLEAR once the last row has been zeroed.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_row == RW'(ROWS - 1)) begin
            state_nxt = READY;
        end
    end

    // Request qualification; pipeline writes take the single write slot from the host.
    always_comb begin
        legal     = (bus.mem_width_i != 4'd0) && (bus.mem_width_i <= 4'd4);
        acc_wr    = (state == READY) && bus.mem_ce_i && bus.mem_we_i && legal;
        acc_rd    = (state == READY) && bus.mem_ce_i && !bus.mem_we_i && legal;
        host_rdy  = (state == READY) && !(bus.mem_ce_i && bus.mem_we_i);
        host_acc  = host_rdy && bus.host_we_i;
        host_byte = bus.host_addr_i[AW-1:0];
        // Left-justify write data so byte i of the access is always the i-th byte from the top.
        wr_aligned = bus.mem_data_i << {3'd4 - bus.mem_width_i[2:0], 3'b000};
        for (int i = 0; i < 4; i++) begin
            byte_addr[i] = bus.mem_addr_i[AW-1:0] + AW'(i);
        end
    end

    // Gather read bytes most-significant first, right-justified in the word.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (legal && 3'(i) < bus.mem_width_i[2:0]) begin
                rd_word = {rd_word[DATA_W-9:0],
                           mem[byte_addr[i][1:0]][byte_addr[i][AW-1:2]]};
            end
        end
    end

    // Per-bank write port steering: clear sweep, then pipeline, then host.
    always_comb begin
        bank_we = '0;
        for (int b = 0; b < 4; b++) begin
            bank_row[b]  = clr_row;
            bank_wdat[b] = 8'h00;
        end
        if (state == CLEAR) begin
            bank_we = 4'hF;
        end else if (acc_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < bus.mem_width_i[2:0]) begin
                    bank_we[byte_addr[i][1:0]]   = 1'b1;
                    bank_row[byte_addr[i][1:0]]  = byte_addr[i][AW-1:2];
                    bank_wdat[byte_addr[i][1:0]] = wr_aligned[DATA_W-1-8*i -: 8];
                end
            end
        end else if (host_acc) begin
            bank_we[host_byte[1:0]]   = 1'b1;
            bank_row[host_byte[1:0]]  = host_byte[AW-1:2];
            bank_wdat[host_byte[1:0]] = bus.host_data_i;
        end
    end

    // Byte-bank storage; each bank has its own row address.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bank_we[b]) begin
                mem[b][bank_row[b]] <= bank_wdat[b];
            end
        end
    end

    // Registered read data and sticky illegal-width flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (state == CLEAR) begin
            data_q <= '0;
        end else if (bus.mem_ce_i) begin
            if (!legal) begin
                err_q <= 1'b1;
                if (!bus.mem_we_i) begin
                    data_q <= '0;
                end
            end else if (acc_rd) begin
                data_q <= rd_word;
            end
        end
    end

    assign bus.mem_data_o   = data_q;
    assign bus.err_o        = err_q;
    assign bus.init_done_o  = (state == READY);
    assign bus.host_ready_o = host_rdy;
endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every wait on init_done_o is bounded.
module tb_data_mem;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    data_mem_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.mem_ce_i    = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_width_i = 4'd0;
        bus.mem_data_i  = '0;
        bus.host_we_i   = 1'b0;
        bus.host_addr_i = '0;
        bus.host_data_i = 8'h00;
    endtask

    task automatic pipe_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1;
        bus.mem_addr_i = a; bus.mem_width_i = w; bus.mem_data_i = d;
        @(negedge clk);
        bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0;
    endtask

    task automatic pipe_read(input logic [31:0] a, input logic [3:0] w, output logic [31:0] d);
        @(negedge clk);
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0;
        bus.mem_addr_i = a; bus.mem_width_i = w;
        @(negedge clk);
        bus.mem_ce_i = 1'b0;
        d = bus.mem_data_o;
    endtask

    // Counts falling edges until init_done_o is seen, bounded.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (bus.init_done_o !== 1'b1 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.init_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", bus.init_done_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err_o); end
        n_cmp++; if (bus.mem_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.mem_data_o); end
        n_cmp++; if (bus.host_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_host_ready got %b want 0", bus.host_ready_o); end
        rst = 1'b0;
        cycles = 0;
        while (bus.init_done_o !== 1'b1 && cycles < 5000) begin
            if (cycles == 10) begin
                bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_width_i = 4'd0;
                bus.host_we_i = 1'b1; bus.host_addr_i = 32'd40; bus.host_data_i = 8'hEE;
                #1;
                n_cmp++; if (bus.host_ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_host_ready got %b want 0", bus.host_ready_o); end
            end
            if (cycles == 11) begin
                n_cmp++; if (bus.mem_data_o !== 32'h0) begin n_fail++; $display("FAIL clear_data got %h want 0", bus.mem_data_o); end
                idle_inputs();
            end
            @(negedge clk);
            cycles++;
        end
        n_cmp++; if (cycles != DEPTH / 4) begin n_fail++; $display("FAIL init_cycles got %0d want %0d", cycles, DEPTH / 4); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL clear_ignores_err got %b want 0", bus.err_o); end
        n_cmp++; if (bus.host_ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_host_ready got %b want 1", bus.host_ready_o); end
    endtask

    task automatic test_zero_fill();
        logic [31:0] d;
        pipe_read(32'd0, 4'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL zero_0 got %h want 0", d); end
        pipe_read(32'd1234, 4'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL zero_1234 got %h want 0", d); end
        pipe_read(32'(DEPTH - 4), 4'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL zero_top got %h want 0", d); end
        pipe_read(32'd40, 4'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_host_dropped got %h want 0", d); end
    endtask

    task automatic test_unaligned();
        logic [31:0] d;
        pipe_write(32'd6, 4'd4, 32'hAABBCCDD);
        pipe_read(32'd7, 4'd2, d);
        n_cmp++; if (d !== 32'h0000BBCC) begin n_fail++; $display("FAIL rd7_w2 got %h want 0000bbcc", d); end
        pipe_read(32'd9, 4'd1, d);
        n_cmp++; if (d !== 32'h000000DD) begin n_fail++; $display("FAIL rd9_w1 got %h want 000000dd", d); end
        pipe_read(32'd5, 4'd4, d);
        n_cmp++; if (d !== 32'h00AABBCC) begin n_fail++; $display("FAIL rd5_w4 got %h want 00aabbcc", d); end
        pipe_write(32'd100, 4'd3, 32'hFF123456);
        n_cmp++; if (bus.mem_data_o !== 32'h00AABBCC) begin n_fail++; $display("FAIL write_holds_data got %h want 00aabbcc", bus.mem_data_o); end
        pipe_read(32'd99, 4'd4, d);
        n_cmp++; if (d !== 32'h00123456) begin n_fail++; $display("FAIL rd99_w4 got %h want 00123456", d); end
        pipe_read(32'd103, 4'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd103_untouched got %h want 0", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        pipe_write(32'(DEPTH - 1), 4'd2, 32'h00001122);
        pipe_read(32'd0, 4'd4, d);
        n_cmp++; if (d !== 32'h22000000) begin n_fail++; $display("FAIL wrap_rd0 got %h want 22000000", d); end
        pipe_read(32'(DEPTH - 1), 4'd1, d);
        n_cmp++; if (d !== 32'h00000011) begin n_fail++; $display("FAIL wrap_top got %h want 00000011", d); end
        pipe_read(32'(2 * DEPTH - 1), 4'd2, d);
        n_cmp++; if (d !== 32'h00001122) begin n_fail++; $display("FAIL wrap_alias got %h want 00001122", d); end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_before got %b want 0", bus.err_o); end
        pipe_write(32'd16, 4'd5, 32'hFFFFFFFF);
        n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", bus.err_o); end
        pipe_read(32'd16, 4'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL w5_no_write got %h want 0", d); end
        pipe_read(32'd6, 4'd4, d);
        n_cmp++; if (d !== 32'hAABBCCDD) begin n_fail++; $display("FAIL rd6_w4 got %h want aabbccdd", d); end
        pipe_read(32'd6, 4'd0, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL w0_read_data got %h want 0", d); end
        n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", bus.err_o); end
    endtask

    task automatic test_host();
        logic [31:0] d;
        @(negedge clk);
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'd200;
        bus.mem_width_i = 4'd1; bus.mem_data_i = 32'h77;
        bus.host_we_i = 1'b1; bus.host_addr_i = 32'd40; bus.host_data_i = 8'h5A;
        #1;
        n_cmp++; if (bus.host_ready_o !== 1'b0) begin n_fail++; $display("FAIL host_blocked got %b want 0", bus.host_ready_o); end
        @(negedge clk);
        idle_inputs();
        pipe_read(32'd40, 4'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL host_dropped got %h want 0", d); end
        @(negedge clk);
        bus.host_we_i = 1'b1; bus.host_addr_i = 32'd40; bus.host_data_i = 8'h5A;
        #1;
        n_cmp++; if (bus.host_ready_o !== 1'b1) begin n_fail++; $display("FAIL host_accept got %b want 1", bus.host_ready_o); end
        @(negedge clk);
        bus.host_we_i = 1'b0;
        pipe_read(32'd40, 4'd1, d);
        n_cmp++; if (d !== 32'h0000005A) begin n_fail++; $display("FAIL host_rd40 got %h want 0000005a", d); end
        pipe_read(32'd200, 4'd1, d);
        n_cmp++; if (d !== 32'h00000077) begin n_fail++; $display("FAIL pipe_rd200 got %h want 00000077", d); end
        @(negedge clk);
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'd40; bus.mem_width_i = 4'd1;
        bus.host_we_i = 1'b1; bus.host_addr_i = 32'd40; bus.host_data_i = 8'hA5;
        @(negedge clk);
        idle_inputs();
        n_cmp++; if (bus.mem_data_o !== 32'h0000005A) begin n_fail++; $display("FAIL same_cycle_old got %h want 0000005a", bus.mem_data_o); end
        pipe_read(32'd40, 4'd1, d);
        n_cmp++; if (d !== 32'h000000A5) begin n_fail++; $display("FAIL same_cycle_new got %h want 000000a5", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [3] = '{32'h01020304, 32'h11223344, 32'hDEADBEEF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_width_i = 4'd4;
            bus.mem_addr_i = 32'(300 + 4 * i); bus.mem_data_i = exp_q[i];
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if (bus.mem_data_o !== exp_q[i-1]) begin
                    n_fail++; $display("FAIL b2b_rd%0d got %h want %h", i - 1, bus.mem_data_o, exp_q[i-1]);
                end
            end
            bus.mem_we_i = 1'b0; bus.mem_ce_i = (i < 3); bus.mem_addr_i = 32'(300 + 4 * i);
        end
        idle_inputs();
    endtask

    task automatic test_rst_restart();
        logic [31:0] d;
        int          cycles;
        pipe_read(32'd6, 4'd4, d);
        n_cmp++; if (d !== 32'hAABBCCDD) begin n_fail++; $display("FAIL pre_rst_rd got %h want aabbccdd", d); end
        @(negedge clk);
        bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'd6; bus.mem_width_i = 4'd4;
        rst = 1'b1;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        n_cmp++; if (bus.mem_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_discard got %h want 0", bus.mem_data_o); end
        repeat (500) @(negedge clk);
        n_cmp++; if (bus.init_done_o !== 1'b0) begin n_fail++; $display("FAIL mid_clear_done got %b want 0", bus.init_done_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_init(cycles);
        n_cmp++; if (cycles != DEPTH / 4) begin n_fail++; $display("FAIL reclear_cycles got %0d want %0d", cycles, DEPTH / 4); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_clears_err got %b want 0", bus.err_o); end
        pipe_read(32'd6, 4'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reclear_rd6 got %h want 0", d); end
        pipe_read(32'(DEPTH - 1), 4'd2, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reclear_wrap got %h want 0", d); end
        pipe_read(32'd40, 4'd1, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reclear_rd40 got %h want 0", d); end
        pipe_read(32'd304, 4'd4, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reclear_rd304 got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_unaligned();
        test_wrap();
        test_illegal();
        test_host();
        test_back_to_back();
        test_rst_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressed packet/data memory that responds to the memory-initiator port driven by the processing pipeline (parser, matcher and executor through the processor mux). It serves single-cycle-issue reads and writes of 1–4 bytes at any byte alignment, big-endian, with one-cycle registered read latency. A secondary host byte-write port loads packets and tables. After reset, an internal sweep zero-fills the whole array before any access is accepted.

## Interface
- `DATA_W`, default 32: data bus width; equals `DATA_BUS`.
- `ADDR_W`, default 32: address bus width; equals `ADDR_BUS`.
- `DEPTH`, default 4096: size in bytes; power of two, multiple of 4.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_ce_i`  in  1  access request, one access per cycle it is high.
- `mem_we_i`  in  1  1 = write, 0 = read; sampled with `mem_ce_i`.
- `mem_addr_i`  in  ADDR_W  byte address of the first (most significant) byte.
- `mem_width_i`  in  4  byte count; legal values 1–4.
- `mem_data_i`  in  DATA_W  write data, right-justified (low `width` bytes used).
- `mem_data_o`  out  DATA_W  registered read data, right-justified, upper bytes zero.
- `host_we_i`  in  1  host byte-write request.
- `host_addr_i`  in  ADDR_W  host byte address.
- `host_data_i`  in  8  host write byte.
- `host_ready_o`  out  1  host write accepted this cycle when high together with `host_we_i`.
- `init_done_o`  out  1  high once the zero-fill sweep has completed.
- `err_o`  out  1  sticky; set by an illegal-width access, cleared only by `rst`.

## Operation
- Storage: 4 byte-wide banks of `DEPTH/4` rows. Byte address `a` maps to bank `a[1:0]`, row `a >> 2`. Each bank has its own row address, so an unaligned access spanning two rows completes in one cycle.
- Addresses are taken modulo `DEPTH`. Upper bits are ignored, and byte `i` of an access is at `(addr + i) mod DEPTH`, so accesses wrap past the end.
- Byte order is big-endian. Byte at `addr` holds `data[8*w-1 -: 8]`; byte at `addr + w - 1` holds `data[7:0]`.
- Writes update exactly `w` bytes. No other byte changes.
- Reads return `w` bytes right-justified; bits above `8*w` are 0.
- Illegal width (0 or >4) with `mem_ce_i`: no bytes written, `err_o` set, and on a read `mem_data_o` becomes 0.
- FSM states:
  - CLEAR, entered on `rst`. A row counter runs 0 → `DEPTH/4 - 1`, writing 0 to all four banks at that row each cycle.
  - READY, entered after the last row is written. `init_done_o` goes high on entry.
  - In CLEAR, all `mem_ce_i` and host requests are ignored, `host_ready_o` = 0, and `mem_data_o` holds 0.
- Host port: `host_ready_o` = READY and not (`mem_ce_i` and `mem_we_i`), combinational. The pipeline write port always has priority. A host write that is not accepted is dropped; the host must hold `host_we_i` until it sees ready.
- Host write and pipeline read in the same cycle, same byte: the read returns the old byte.

## Timing
- Reset values: `mem_data_o` = 0, `init_done_o` = 0, `err_o` = 0, `host_ready_o` = 0, state = CLEAR, row counter = 0.
- Clear duration: `DEPTH/4` cycles after `rst` falls. `init_done_o` rises on the edge after the last row is written (1024 cycles at the default `DEPTH`).
- Read latency 1: a request sampled at edge N drives `mem_data_o` valid after edge N. The value holds until the next read or illegal access; writes do not change `mem_data_o`.
- Write: commits at the sampling edge. A read issued in the following cycle sees the new data. There is no same-cycle bypass.
- Back-to-back accesses every cycle are supported with no stalls.
- `rst` asserted mid-clear or mid-operation: returns to CLEAR, restarts the counter at 0, and zero-fills again. Any in-flight read result is discarded (`mem_data_o` = 0).

## Test plan
- Reset then wait for `init_done_o`: it rises exactly `DEPTH/4` cycles after `rst` deasserts. Reads of width 4 at addresses 0, 1234 and `DEPTH-4` return 0x00000000.
- Write width 4, addr 6, data 0xAABBCCDD, then read width 2 at addr 7: `mem_data_o` = 0x0000BBCC one cycle after the read request. Read width 1 at addr 9 returns 0x000000DD.
- Write width 2 at addr `DEPTH-1`, data 0x1122: byte `DEPTH-1` = 0x11 and byte 0 = 0x22. A width-4 read at addr 0 returns 0x22000000.
- Width 5 write of 0xFFFFFFFF at addr 16: `err_o` goes to 1 and stays 1. A read of width 4 at addr 16 returns 0. A width-0 read drives `mem_data_o` to 0.
- Host write 0x5A at addr 40 in the same cycle as a pipeline write: `host_ready_o` = 0 and no host write occurs. The next cycle, with the pipeline idle, the write is accepted and a read at addr 40 returns 0x0000005A.
- Fill data, then assert `rst` for 1 cycle midway through a second clear sweep: `init_done_o` stays low for a full `DEPTH/4` cycles after the last `rst`, and all prior data reads back as 0.
